// File: rtl/sprite_row_sched.sv
// Double-buffered chess-board row scheduler: fetches the next scanline's 8 squares
// during hblank and exposes per-pixel piece code and sprite origin combinationally.
module sprite_row_sched #(
  parameter int BOARD_X0 = 80,
  parameter int BOARD_Y0 = 0,
  parameter int SQ       = 60,
  parameter int PAD      = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525
) (
  input  logic       vga_clk,
  input  logic       resetn,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       brd_req,
  output logic [5:0] brd_addr,
  input  logic       brd_ack,
  input  logic [3:0] brd_data,
  output logic [3:0] piece_code,
  output logic [9:0] offsetX,
  output logic [9:0] offsetY,
  output logic       piece_on,
  output logic       underrun
);

  localparam logic [10:0] X0     = 11'(BOARD_X0);
  localparam logic [10:0] Y0     = 11'(BOARD_Y0);
  localparam logic [10:0] SQW    = 11'(SQ);
  localparam logic [10:0] PADW   = 11'(PAD);
  localparam logic [9:0]  X_FETCH = 10'(H_ACTIVE);
  localparam logic [9:0]  X_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  Y_LAST  = 10'(V_TOTAL - 1);

  // Square index from a board-relative offset using the 7 inner boundaries.
  function automatic logic [2:0] cell_of(input logic [10:0] d);
    cell_of = '0;
    for (int i = 1; i < 8; i++)
      if (d >= 11'(i * SQ)) cell_of = 3'(i);
  endfunction

  function automatic logic in_span(input logic [9:0] v, input int lo);
    logic signed [11:0] d;
    d = $signed({2'b00, v}) - $signed(12'(lo));
    in_span = (d >= 12'sd0) && (d < $signed(12'(8 * SQ)));
  endfunction

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      row_q, col_q;
  logic [7:0][3:0] fetch_q, fetch_d, active_q;
  logic            underrun_q;
  logic [9:0]      ny;
  logic            ny_on, start, zfill, wr, swap, fail;
  logic [2:0]      cx, cy;

  assign ny    = (DrawY == Y_LAST) ? 10'd0 : DrawY + 10'd1;
  assign ny_on = in_span(ny, BOARD_Y0);

  assign brd_req  = (state_q == FETCH);
  assign brd_addr = {row_q, col_q};
  assign underrun = underrun_q;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    zfill   = 1'b0;
    wr      = 1'b0;
    swap    = 1'b0;
    fail    = 1'b0;
    case (state_q)
      IDLE:
        if (DrawX == X_FETCH) begin
          if (ny_on) begin
            start   = 1'b1;
            state_d = FETCH;
          end else begin
            zfill   = 1'b1;
            state_d = DONE;
          end
        end
      FETCH: begin
        wr = brd_ack;
        // A col-7 ack landing on the last pixel still counts as a completed row.
        if (DrawX == X_LAST) begin
          state_d = IDLE;
          if (brd_ack && col_q == 3'd7) swap = 1'b1;
          else                          fail = 1'b1;
        end else if (brd_ack && col_q == 3'd7) begin
          state_d = DONE;
        end
      end
      DONE:
        if (DrawX == X_LAST) begin
          swap    = 1'b1;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fetch_d = fetch_q;
    if (zfill) fetch_d = '0;
    if (wr)    fetch_d[col_q] = brd_data;
  end

  always_ff @(posedge vga_clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      fetch_q    <= '0;
      active_q   <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_q <= fetch_d;
      if (start) begin
        row_q <= cell_of(11'(ny) - Y0);
        col_q <= '0;
      end else if (wr) begin
        col_q <= col_q + 3'd1;
      end
      if (swap)      active_q <= fetch_d;
      else if (fail) active_q <= '0;
      if (fail) underrun_q <= 1'b1;
    end
  end

  always_comb begin
    piece_code = '0;
    offsetX    = '0;
    offsetY    = '0;
    piece_on   = 1'b0;
    cx = cell_of(11'(DrawX) - X0);
    cy = cell_of(11'(DrawY) - Y0);
    if (in_span(DrawX, BOARD_X0) && in_span(DrawY, BOARD_Y0)) begin
      piece_code = active_q[cx];
      offsetX    = 10'(X0 + 11'(cx) * SQW + PADW);
      offsetY    = 10'(Y0 + 11'(cy) * SQW + PADW);
      piece_on   = (active_q[cx] != 4'd0);
    end
  end

endmodule
